// File: rtl/sn_pkg.sv
// sn_pkg: shared types and constants for the stochastic-core result path.
//   sn_ser_state_t : serializer FSM state encoding
//   SN_RES_W       : width of one averaged result word {over_flag, prob[16:8]}
//   SN_SER_START / SN_SER_STOP : line levels of the frame start and stop bits
// Optional macro SN_SER_PARITY_EN adds the PARITY state.
package sn_pkg;

  localparam int   SN_RES_W     = 10;
  localparam logic SN_SER_START = 1'b1;
  localparam logic SN_SER_STOP  = 1'b0;

  typedef enum logic [2:0] {
    SER_IDLE   = 3'd0,
    SER_START  = 3'd1,
    SER_DATA   = 3'd2,
`ifdef SN_SER_PARITY_EN
    SER_PARITY = 3'd3,
`endif
    SER_STOP   = 3'd4
  } sn_ser_state_t;

endpackage

// File: rtl/sn_result_fifo.sv
// sn_result_fifo: small synchronous FIFO for result words.
//   clk, rst_n     : clock, asynchronous active-high reset (clears contents)
//   push, wdata    : write request; accepted when not full or when popping
//   pop, rdata     : rdata shows the head; pop removes it (ignored if empty)
//   full, empty    : occupancy flags
//   cnt            : number of stored words
// DEPTH must be a power of two so the pointers wrap naturally.
module sn_result_fifo #(
  parameter  int DW    = 10,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wptr, rptr;
  logic                     do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop at the same edge frees the slot, so a push into a full FIFO is accepted.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sn_result_serializer.sv
// sn_result_serializer: buffers averaged result words from the stochastic core
// and shifts each out as a framed serial stream on one pin.
//   clk, rst_n          : clock, asynchronous active-high reset
//   res_valid, res_data : one-cycle result strobe and word
//   clr_ovf             : clears overflow (a simultaneous drop wins)
//   ser_out             : frame line: start(1), data LSB first, [parity], stop(0)
//   ser_frame           : high for every cycle of a frame
//   busy                : FIFO non-empty or a frame in progress
//   overflow            : sticky, a result was dropped on a full FIFO
// Macro SN_SER_PARITY_EN: adds an even-parity bit between MSB and stop.
module sn_result_serializer
  import sn_pkg::*;
#(
  parameter int DATA_W     = SN_RES_W,
  parameter int BIT_CYCLES = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic              clr_ovf,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              busy,
  output logic              overflow
);

  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int          BW       = $clog2(DATA_W + 1);
  localparam logic [7:0]  CYC_LAST = 8'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  sn_ser_state_t     state;
  logic [7:0]        cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_cnt, cnt_nxt;
  logic              fifo_full, fifo_empty;
  logic              cyc_end, frame_free, pop, push_ok, drop, to_idle;
`ifdef SN_SER_PARITY_EN
  logic              par;
`endif

  assign cyc_end    = (cyc_cnt == CYC_LAST);
  // The line can take a new word while idle or on the last stop-bit cycle.
  assign frame_free = (state == SER_IDLE) || (state == SER_STOP && cyc_end);
  assign pop        = frame_free && !fifo_empty;
  assign to_idle    = frame_free && fifo_empty;
  assign push_ok    = res_valid && (!fifo_full || pop);
  assign drop       = res_valid && fifo_full && !pop;
  assign cnt_nxt    = fifo_cnt + CW'(push_ok) - CW'(pop);

  sn_result_fifo #(.DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_valid),
    .wdata (res_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= SER_IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
`ifdef SN_SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      cyc_cnt <= cyc_end ? 8'd0 : cyc_cnt + 8'd1;
      if (pop) begin
        shreg     <= fifo_rdata;
        ser_out   <= SN_SER_START;
        ser_frame <= 1'b1;
        state     <= SER_START;
        cyc_cnt   <= 8'd0;
`ifdef SN_SER_PARITY_EN
        par       <= ^fifo_rdata;
`endif
      end else begin
        unique case (state)
          SER_IDLE: cyc_cnt <= 8'd0;
          SER_START: if (cyc_end) begin
            bit_cnt <= '0;
            ser_out <= shreg[0];
            state   <= SER_DATA;
          end
          SER_DATA: if (cyc_end) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef SN_SER_PARITY_EN
              ser_out <= par;
              state   <= SER_PARITY;
`else
              ser_out <= SN_SER_STOP;
              state   <= SER_STOP;
`endif
            end else begin
              shreg   <= shreg >> 1;
              ser_out <= shreg[1];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
`ifdef SN_SER_PARITY_EN
          SER_PARITY: if (cyc_end) begin
            ser_out <= SN_SER_STOP;
            state   <= SER_STOP;
          end
`endif
          SER_STOP: if (cyc_end) begin
            // FIFO empty here (otherwise pop would have restarted the frame)
            ser_frame <= 1'b0;
            state     <= SER_IDLE;
          end
          default: state <= SER_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= !to_idle || (cnt_nxt != '0);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sn_result_serializer.sv
// tb_sn_result_serializer: randomized + directed bench for sn_result_serializer.
// Reference model: a queue of buffered words and a queue of future line levels;
// a whole frame's levels are appended when the line is free and a word waits.
module tb_sn_result_serializer;

  localparam int DW = 10, BC = 4, DEPTH = 2;
`ifdef SN_SER_PARITY_EN
  localparam int          FLEN    = (DW + 3) * BC;
  localparam logic [31:0] EXP_2A5 = 32'h0000_0D4B;
  localparam logic [31:0] EXP_B2B = 32'h00FF_E803;
`else
  localparam int          FLEN    = (DW + 2) * BC;
  localparam logic [31:0] EXP_2A5 = 32'h0000_054B;
  localparam logic [31:0] EXP_B2B = 32'h007F_F003;
`endif

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          res_valid = 1'b0, clr_ovf = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic          ser_out, ser_frame, busy, overflow;

  sn_result_serializer #(.DATA_W(DW), .BIT_CYCLES(BC), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_data  (res_data),
    .clr_ovf   (clr_ovf),
    .ser_out   (ser_out),
    .ser_frame (ser_frame),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_fifo[$];
  bit            m_line[$];
  logic          m_out = 0, m_frame = 0, m_busy = 0, m_ovf = 0;
  logic [DW-1:0] m_w;
  bit            m_drop;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_fifo.delete();
      m_line.delete();
      m_out = 0; m_frame = 0; m_busy = 0; m_ovf = 0;
    end else begin
      if (m_line.size() == 0 && m_fifo.size() != 0) begin
        m_w = m_fifo.pop_front();
        repeat (BC) m_line.push_back(1'b1);
        for (int k = 0; k < DW; k++) repeat (BC) m_line.push_back(m_w[k]);
`ifdef SN_SER_PARITY_EN
        repeat (BC) m_line.push_back(^m_w);
`endif
        repeat (BC) m_line.push_back(1'b0);
      end
      m_drop = 0;
      if (res_valid) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(res_data);
        else m_drop = 1;
      end
      if (m_drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (m_line.size() != 0) begin
        m_out = m_line.pop_front();
        m_frame = 1;
      end else begin
        m_out = 0;
        m_frame = 0;
      end
      m_busy = m_frame || (m_fifo.size() != 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input logic [DW-1:0] d, input logic c);
    @(negedge clk);
    chk("ser_out", ser_out, m_out);
    chk("ser_frame", ser_frame, m_frame);
    chk("busy", busy, m_busy);
    chk("overflow", overflow, m_ovf);
    res_valid = v; res_data = d; clr_ovf = c;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) step(0, '0, 0);
    chk("idle_timeout", busy, 0);
  endtask

  // Measures the contiguous ser_frame run and samples ser_out mid-bit.
  task automatic grab(output int len, output logic [31:0] bits);
    int t = 0;
    len = 0; bits = '0;
    while (!ser_frame && t < 20) begin step(0, '0, 0); t++; end
    while (ser_frame && len < 400) begin
      if (len % BC == BC / 2) bits[len / BC] = ser_out;
      len++;
      step(0, '0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    logic [31:0] bits;
    logic        seen;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_frame", ser_frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b0;
    repeat (2) step(0, '0, 0);

    // single word
    step(1, 10'h2A5, 0);
    grab(len, bits);
    chk("frame_len", len, FLEN);
    chk("frame_bits", bits, EXP_2A5);
    wait_idle();

    // two words two cycles apart -> frames back to back
    step(1, 10'h001, 0);
    step(0, '0, 0);
    step(1, 10'h3FF, 0);
    grab(len, bits);
    chk("b2b_len", len, 2 * FLEN);
    chk("b2b_bits", bits, EXP_B2B);
    chk("b2b_ovf", overflow, 0);
    wait_idle();

    // overflow while a frame holds the line
    step(1, 10'h155, 0);
    repeat (3) step(0, '0, 0);
    step(1, 10'h100, 0);
    step(1, 10'h0F0, 0);
    step(1, 10'h00F, 0);
    step(0, '0, 0);
    chk("ovf_set", overflow, 1);
    step(0, '0, 1);
    step(1, 10'h3C3, 1);      // drop and clear at the same edge
    step(0, '0, 0);
    chk("ovf_set_wins", overflow, 1);
    step(0, '0, 1);
    step(0, '0, 0);
    chk("ovf_clr", overflow, 0);
    wait_idle();

    // reset during data bit 5
    step(1, 10'h3FF, 0);
    repeat (27) step(0, '0, 0);
    chk("pre_rst_out", ser_out, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("async_rst_out", ser_out, 0);
    chk("async_rst_frame", ser_frame, 0);
    repeat (2) step(0, '0, 0);
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, '0, 0);
      seen |= ser_frame;
    end
    chk("post_rst_busy", busy, 0);
    chk("no_residual_frame", seen, 0);

    // randomized traffic, alternating sparse and bursty phases
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = ((i / 500) % 2 != 0) ? 3 : 40;
      step($urandom_range(0, r) == 0, DW'($urandom), $urandom_range(0, 60) == 0);
    end
    step(0, '0, 1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sn_result_serializer.md
# sn_result_serializer

Downstream stage of the stochastic add/multiply core. Captures each 10-bit averaged probability word `{over_flag, prob_counter[16:8]}` when the core closes a 2^17+1-cycle accumulation window. Buffers up to two words and shifts each out as a framed serial bit stream on a single output pin, so results leave the chip on one pad instead of ten.

## Interface
Parameters:
- `DATA_W`, 10 — width of the result word.
- `BIT_CYCLES`, 4 — clocks each serial bit is held; legal range 1..255.
- `FIFO_DEPTH`, 2 — result words buffered; power of two, minimum 2.

Ports:
- `clk`  in  1 — clock.
- `rst_n`  in  1 — reset, asynchronous, active-high.
- `res_valid`  in  1 — one-cycle pulse: `res_data` holds a new result.
- `res_data`  in  `DATA_W` — averaged result from the core.
- `clr_ovf`  in  1 — synchronous clear of `overflow`.
- `ser_out`  out  1 — serial frame output; idle level 0.
- `ser_frame`  out  1 — high for every cycle of a frame, start through stop.
- `busy`  out  1 — high when the FIFO is non-empty or the FSM is not IDLE.
- `overflow`  out  1 — sticky; a result was dropped.

## Operation
- Reset value of every register is 0:
  - `ser_out`=0, `ser_frame`=0, `busy`=0, `overflow`=0.
  - FIFO empty; FSM in IDLE; bit and cycle counters 0.
- Push: on `res_valid`=1, `res_data` is written to the FIFO tail.
- Full FIFO:
  - A push with no pop at the same edge is dropped and sets `overflow`.
  - A push coinciding with a pop at the same edge is accepted.
- `clr_ovf`=1 clears `overflow` at the next edge. If a drop occurs at the same edge, set wins.
- FSM states: IDLE, START, DATA, PARITY (only with the Configuration macro), STOP.
- IDLE → START: FIFO non-empty. The head is popped into the shift register and `ser_out` becomes 1.
- START → DATA: after `BIT_CYCLES` clocks. `ser_out` shows shift register bit 0, LSB first.
- DATA: shifts right every `BIT_CYCLES` clocks. Exits after `DATA_W` bits, to PARITY if enabled, else to STOP.
- PARITY → STOP: after `BIT_CYCLES` clocks.
- STOP: `ser_out`=0 for `BIT_CYCLES` clocks. Then:
  - FIFO non-empty: pop and go directly to START (no idle gap).
  - FIFO empty: go to IDLE.
- `ser_frame` is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Reset asserted mid-frame aborts immediately:
  - `ser_out`/`ser_frame` go to 0 asynchronously.
  - FIFO contents are discarded.

## Timing
- All outputs are registered.
- `res_valid` sampled at edge t, FIFO empty, FSM IDLE:
  - Word written at edge t.
  - Popped at edge t+1.
  - Start bit visible on `ser_out` from edge t+1.
  - First-bit latency: 1 cycle after the write edge.
- Frame length: (`DATA_W`+2)·`BIT_CYCLES` clocks. Add `BIT_CYCLES` with parity enabled.
- With defaults and no parity, a frame is 48 clocks. This is far below the 131073-cycle result period, so overflow occurs only under direct bench stimulus.
- Bit k of the data (k=0..`DATA_W`-1) is held from cycle (1+k)·`BIT_CYCLES` to (2+k)·`BIT_CYCLES`-1 after frame start.

## Configuration
- `SN_SER_PARITY_EN` defined:
  - PARITY state is compiled in.
  - One even-parity bit (XOR of all `DATA_W` data bits) is sent after the MSB and before stop.
- Not defined:
  - No PARITY state and no parity logic.
  - Frame is start, data, stop.

## Structure
- Shared package `sn_pkg` holds:
  - FSM state enum `sn_ser_state_t`.
  - Constants `SN_RES_W`=10, `SN_SER_START`=1'b1, `SN_SER_STOP`=1'b0.
- One sub-module, `sn_result_fifo`: synchronous FIFO with push/pop/full/empty and the same asynchronous active-high reset.
- The top holds the FSM, bit-cycle counter, bit counter, shift register and overflow flag.

## Test plan
- Reset check: assert `rst_n`=1 for 3 cycles → `ser_out`=0, `ser_frame`=0, `busy`=0, `overflow`=0.
- Single word `res_data`=10'h2A5, defaults, no parity → `ser_out` sequence is:
  - start 1,
  - then bits 1,0,1,0,0,1,0,1,0,1 (LSB first),
  - then stop 0,
  - each held 4 clocks, `ser_frame` high 48 clocks.
- Two pushes 10'h001 then 10'h3FF, two cycles apart → two frames back-to-back; second start bit immediately follows the first stop bit; `overflow` stays 0.
- Three pushes 10'h100, 10'h0F0, 10'h00F on consecutive cycles → first two words serialized; `overflow`=1 after the third push; `clr_ovf` pulse returns it to 0.
- With `SN_SER_PARITY_EN`, `res_data`=10'h007 → parity bit 1 between MSB and stop; frame 52 clocks.
- Assert `rst_n` during DATA bit 5 of a frame → `ser_out`=0 the same cycle; `busy`=0 after release; no residual frame emitted.
